eth_tx_arbiter: RTL and testbench

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_arb_pkg.sv | 24 ++
 rtl/eth_rr_arb.sv | 32 +++
 rtl/eth_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared types and constants for the Ethernet TX payload arbiter.
package eth_arb_pkg;

    localparam int STAT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    // (base + off) wrapped into [0, n); callers keep base < n and off <= n
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/eth_rr_arb.sv
// Combinational round-robin search: first requester after last_grant wins.
module eth_rr_arb
    import eth_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        last_grant,
    output logic [PW-1:0]        grant,
    output logic                 grant_valid
);

    // Scan ports in rotating order starting one past the previous winner
    always_comb begin
        logic [PW-1:0] idx;
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int off = 1; off <= NUM_PORTS; off++) begin
            idx = PW'(wrap_idx(int'(last_grant), off, NUM_PORTS));
            if (!grant_valid && req[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end else begin
                grant       = grant;
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic round-robin payload arbiter issuing one header request per frame.
// Optional per-port frame counters are enabled with ETH_TX_ARB_STATS_EN.
module eth_tx_arbiter
    import eth_arb_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = 512,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int PW         = $clog2(NUM_PORTS)
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic                             arb_enable,
    input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
    output logic [NUM_PORTS-1:0]             s_axis_tready,
    input  logic [NUM_PORTS-1:0]             s_axis_tlast,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_hdr_valid,
    input  logic                             m_hdr_ready,
    output logic [PW-1:0]                    m_hdr_port,
    output logic [NUM_PORTS*STAT_WIDTH-1:0]  stat_frame_count,
    output logic                             busy
);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] last_grant_q, last_grant_d;
    logic [PW-1:0] rr_grant;
    logic          rr_valid;
    logic          in_data_s;
    logic          beat_last_s;

    eth_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_rr (
        .req         (s_axis_tvalid),
        .last_grant  (last_grant_q),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    assign in_data_s   = (state_q == DATA);
    assign beat_last_s = in_data_s && s_axis_tvalid[grant_q] && m_axis_tready && s_axis_tlast[grant_q];

    // Frame sequencing; arb_enable only gates the decision taken in IDLE
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (arb_enable && rr_valid) begin
                    state_d = HDR;
                    grant_d = rr_grant;
                end else begin
                    state_d = IDLE;
                end
            end
            HDR: begin
                if (m_hdr_ready) begin
                    state_d = DATA;
                end else begin
                    state_d = HDR;
                end
            end
            DATA: begin
                if (beat_last_s) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end else begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PW'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Steer the granted requester onto the merged stream during DATA only
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = in_data_s && s_axis_tvalid[grant_q];
        m_axis_tlast  = in_data_s && s_axis_tlast[grant_q];
        s_axis_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == PW'(i)) begin
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                s_axis_tready[i] = in_data_s && m_axis_tready;
            end else begin
                s_axis_tready[i] = 1'b0;
            end
        end
    end

    assign m_hdr_valid = (state_q == HDR);
    assign m_hdr_port  = grant_q;
    assign busy        = (state_q != IDLE);

`ifdef ETH_TX_ARB_STATS_EN
    logic [NUM_PORTS*STAT_WIDTH-1:0] stat_cnt_q, stat_cnt_d;

    // Count completed frames per port, wrapping naturally at the counter width
    always_comb begin
        stat_cnt_d = stat_cnt_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (beat_last_s && (grant_q == PW'(i))) begin
                stat_cnt_d[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt_q[i*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
            end else begin
                stat_cnt_d[i*STAT_WIDTH +: STAT_WIDTH] = stat_cnt_q[i*STAT_WIDTH +: STAT_WIDTH];
            end
        end
    end

    // Counter registers
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            stat_cnt_q <= '0;
        end else begin
            stat_cnt_q <= stat_cnt_d;
        end
    end

    assign stat_frame_count = stat_cnt_q;
`else
    assign stat_frame_count = '0;
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed self-checking bench for eth_tx_arbiter (4 ports, 32-bit data).
module tb_eth_tx_arbiter;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic          arb_enable;
    logic [3:0]    s_tvalid, s_tready, s_tlast;
    logic [127:0]  s_tdata;
    logic [15:0]   s_tkeep;
    logic          m_tvalid, m_tready, m_tlast;
    logic [31:0]   m_tdata;
    logic [3:0]    m_tkeep;
    logic          hdr_valid, hdr_ready;
    logic [1:0]    hdr_port;
    logic [127:0]  stat;
    logic          busy;

    int checks;
    int failures;

    eth_tx_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32)) dut (
        .ap_clk           (ap_clk),
        .ap_rst           (ap_rst),
        .arb_enable       (arb_enable),
        .s_axis_tvalid    (s_tvalid),
        .s_axis_tready    (s_tready),
        .s_axis_tlast     (s_tlast),
        .s_axis_tdata     (s_tdata),
        .s_axis_tkeep     (s_tkeep),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tdata     (m_tdata),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tlast     (m_tlast),
        .m_hdr_valid      (hdr_valid),
        .m_hdr_ready      (hdr_ready),
        .m_hdr_port       (hdr_port),
        .stat_frame_count (stat),
        .busy             (busy)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
        s_tvalid[p]        = v;
        s_tlast[p]         = l;
        s_tdata[p*32 +: 32] = d;
        s_tkeep[p*4 +: 4]   = d[3:0];
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        #1;
        checks++;
        if ({busy, hdr_valid, m_tvalid, s_tready} !== 7'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required 0000000", {busy, hdr_valid, m_tvalid, s_tready});
        end
        checks++;
        if (stat !== 128'd0) begin
            failures++;
            $display("FAIL reset_stats: got %h required 0", stat);
        end
        arb_enable = 1'b1;
        set_port(0, 1'b1, 32'h0000_0055, 1'b1);
        @(negedge ap_clk);
        #1;
        checks++;
        if ({busy, hdr_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_hold_idle: got %b required 00", {busy, hdr_valid});
        end
        set_port(0, 1'b0, 32'h0, 1'b0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic test_single_port();
        logic [31:0] d;
        logic [31:0] exp_stat;
`ifdef ETH_TX_ARB_STATS_EN
        exp_stat = 32'd1;
`else
        exp_stat = 32'd0;
`endif
        @(negedge ap_clk);
        set_port(0, 1'b1, 32'hA0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got busy=%b required 0", busy);
        end
        @(negedge ap_clk);
        #1;
        checks++;
        if ({hdr_valid, hdr_port, m_tvalid, s_tready, busy} !== {1'b1, 2'd0, 1'b0, 4'b0000, 1'b1}) begin
            failures++;
            $display("FAIL single_hdr: got %b required %b", {hdr_valid, hdr_port, m_tvalid, s_tready, busy},
                     {1'b1, 2'd0, 1'b0, 4'b0000, 1'b1});
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge ap_clk);
            d = 32'hA0 + 32'(b);
            set_port(0, 1'b1, d, (b == 2));
            #1;
            checks++;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, hdr_valid} !==
                {1'b1, d, d[3:0], (b == 2), 4'b0001, 1'b0}) begin
                failures++;
                $display("FAIL single_beat%0d: got %h required %h", b,
                         {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, hdr_valid},
                         {1'b1, d, d[3:0], (b == 2), 4'b0001, 1'b0});
            end
        end
        @(negedge ap_clk);
        set_port(0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if ({busy, m_tvalid} !== 2'b00) begin
            failures++;
            $display("FAIL single_done: got %b required 00", {busy, m_tvalid});
        end
        checks++;
        if (stat[31:0] !== exp_stat) begin
            failures++;
            $display("FAIL single_stat: got %h required %h", stat[31:0], exp_stat);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ep;
        logic [31:0] d;
        do_reset();
        @(negedge ap_clk);
        for (int p = 0; p < 4; p++) set_port(p, 1'b1, 32'h10 + 32'(p), 1'b1);
        #1;
        for (int k = 0; k < 6; k++) begin
            ep = 2'(k % 4);
            d  = 32'h10 + 32'(ep);
            @(negedge ap_clk);
            #1;
            checks++;
            if ({hdr_valid, hdr_port, m_tvalid, s_tready} !== {1'b1, ep, 1'b0, 4'b0000}) begin
                failures++;
                $display("FAIL rr_hdr%0d: got %b required %b", k, {hdr_valid, hdr_port, m_tvalid, s_tready},
                         {1'b1, ep, 1'b0, 4'b0000});
            end
            @(negedge ap_clk);
            #1;
            checks++;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, d, d[3:0], 1'b1, 4'b0001 << ep}) begin
                failures++;
                $display("FAIL rr_data%0d: got %h required %h", k, {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                         {1'b1, d, d[3:0], 1'b1, 4'b0001 << ep});
            end
            @(negedge ap_clk);
            #1;
            checks++;
            if ({busy, hdr_valid, m_tvalid} !== 3'b000) begin
                failures++;
                $display("FAIL rr_gap%0d: got %b required 000", k, {busy, hdr_valid, m_tvalid});
            end
        end
        for (int p = 0; p < 4; p++) set_port(p, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_hdr_stall();
        hdr_ready = 1'b0;
        @(negedge ap_clk);
        set_port(3, 1'b1, 32'h33, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge ap_clk);
            #1;
            checks++;
            if ({hdr_valid, hdr_port, m_tvalid, s_tready, busy} !== {1'b1, 2'd3, 1'b0, 4'b0000, 1'b1}) begin
                failures++;
                $display("FAIL stall_cycle%0d: got %b required %b", c, {hdr_valid, hdr_port, m_tvalid, s_tready, busy},
                         {1'b1, 2'd3, 1'b0, 4'b0000, 1'b1});
            end
        end
        hdr_ready = 1'b1;
        @(negedge ap_clk);
        #1;
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, hdr_valid} !==
            {1'b1, 32'h33, 4'h3, 1'b1, 4'b1000, 1'b0}) begin
            failures++;
            $display("FAIL stall_data: got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready, hdr_valid},
                     {1'b1, 32'h33, 4'h3, 1'b1, 4'b1000, 1'b0});
        end
        @(negedge ap_clk);
        set_port(3, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_done: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_enable_drop();
        logic [31:0] d;
        arb_enable = 1'b1;
        @(negedge ap_clk);
        set_port(0, 1'b1, 32'hB0, 1'b0);
        set_port(1, 1'b1, 32'h21, 1'b1);
        set_port(2, 1'b1, 32'h22, 1'b1);
        @(negedge ap_clk);
        #1;
        checks++;
        if ({hdr_valid, hdr_port} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL endrop_hdr: got %b required %b", {hdr_valid, hdr_port}, {1'b1, 2'd0});
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge ap_clk);
            d = 32'hB0 + 32'(b);
            set_port(0, 1'b1, d, (b == 3));
            if (b == 1) arb_enable = 1'b0;
            #1;
            checks++;
            if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, d, d[3:0], (b == 3), 4'b0001}) begin
                failures++;
                $display("FAIL endrop_beat%0d: got %h required %h", b, {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                         {1'b1, d, d[3:0], (b == 3), 4'b0001});
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            if (c == 0) set_port(0, 1'b0, 32'h0, 1'b0);
            #1;
            checks++;
            if ({busy, hdr_valid, m_tvalid, s_tready} !== 7'd0) begin
                failures++;
                $display("FAIL endrop_disabled%0d: got %b required 0000000", c, {busy, hdr_valid, m_tvalid, s_tready});
            end
        end
        arb_enable = 1'b1;
        @(negedge ap_clk);
        #1;
        checks++;
        if ({hdr_valid, hdr_port} !== {1'b1, 2'd1}) begin
            failures++;
            $display("FAIL endrop_resume_hdr: got %b required %b", {hdr_valid, hdr_port}, {1'b1, 2'd1});
        end
        @(negedge ap_clk);
        #1;
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, 32'h21, 4'h1, 1'b1, 4'b0010}) begin
            failures++;
            $display("FAIL endrop_resume_data: got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                     {1'b1, 32'h21, 4'h1, 1'b1, 4'b0010});
        end
        @(negedge ap_clk);
        set_port(1, 1'b0, 32'h0, 1'b0);
        set_port(2, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL endrop_done: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge ap_clk);
        set_port(0, 1'b1, 32'hC0, 1'b0);
        set_port(2, 1'b1, 32'hC2, 1'b0);
        @(negedge ap_clk);
        #1;
        checks++;
        if ({hdr_valid, hdr_port} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL rstmid_hdr: got %b required %b", {hdr_valid, hdr_port}, {1'b1, 2'd2});
        end
        @(negedge ap_clk);
        #1;
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, 32'hC2, 4'h2, 1'b0, 4'b0100}) begin
            failures++;
            $display("FAIL rstmid_data: got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                     {1'b1, 32'hC2, 4'h2, 1'b0, 4'b0100});
        end
        #2;
        ap_rst = 1'b1;
        #1;
        checks++;
        if ({busy, hdr_valid, m_tvalid, m_tlast, s_tready} !== 8'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got %b required 00000000", {busy, hdr_valid, m_tvalid, m_tlast, s_tready});
        end
        checks++;
        if (stat !== 128'd0) begin
            failures++;
            $display("FAIL rstmid_stats: got %h required 0", stat);
        end
        @(negedge ap_clk);
        ap_rst = 1'b0;
        set_port(2, 1'b0, 32'h0, 1'b0);
        set_port(0, 1'b1, 32'hC0, 1'b1);
        @(negedge ap_clk);
        #1;
        checks++;
        if ({hdr_valid, hdr_port} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL rstmid_first_hdr: got %b required %b", {hdr_valid, hdr_port}, {1'b1, 2'd0});
        end
        @(negedge ap_clk);
        #1;
        checks++;
        if ({m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready} !== {1'b1, 32'hC0, 4'h0, 1'b1, 4'b0001}) begin
            failures++;
            $display("FAIL rstmid_first_data: got %h required %h", {m_tvalid, m_tdata, m_tkeep, m_tlast, s_tready},
                     {1'b1, 32'hC0, 4'h0, 1'b1, 4'b0001});
        end
        @(negedge ap_clk);
        set_port(0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_stats();
`ifdef ETH_TX_ARB_STATS_EN
        do_reset();
        @(negedge ap_clk);
        force dut.stat_cnt_q = {96'd0, 32'hFFFF_FFFF};
        #1;
        release dut.stat_cnt_q;
        set_port(0, 1'b1, 32'hD0, 1'b1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        @(negedge ap_clk);
        set_port(0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (stat !== 128'd0) begin
            failures++;
            $display("FAIL stats_wrap: got %h required 0", stat);
        end
`else
        #1;
        checks++;
        if (stat !== 128'd0) begin
            failures++;
            $display("FAIL stats_disabled: got %h required 0", stat);
        end
`endif
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        arb_enable = 1'b0;
        s_tvalid   = 4'd0;
        s_tlast    = 4'd0;
        s_tdata    = 128'd0;
        s_tkeep    = 16'd0;
        m_tready   = 1'b1;
        hdr_ready  = 1'b1;
        ap_rst     = 1'b1;
        test_reset();
        test_single_port();
        test_round_robin();
        test_hdr_stall();
        test_enable_drop();
        test_reset_mid_frame();
        test_stats();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
